sdram_mrs_issuer: RTL
=====================

Name: sdram_mrs_issuer

Overview:
- Controller-side initiator of the SDRAM mode-register-set (MRS) command, i.e. the master end of the device register-file programming interface.
- After reset it holds NOP for a power-up interval. It then accepts a host request carrying burst length, address mode and timing values, encodes them into the packed 32-bit address word, and drives a single-cycle MRS command (CS, RAS, CAS, We all low).
- It then waits tMRD cycles and reports completion.

Parameters:
- PWRUP_CYCLES, 16, NOP cycles after reset before the first request is accepted (>=1).
- TMRD, 2, NOP cycles after MRS before Done (>=1).
- CNT_W, 8, counter width; must hold max(PWRUP_CYCLES, TMRD).
- DEF_MODE, 32'h0402_0130, packed word used by the auto-init option.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Req  in  1  program request; sampled only in IDLE.
- BurstLen  in  8  burst length in beats: 1, 2, 4, 8, 16, 32, 64 or 255.
- AddrMode  in  1  0 = sequential, 1 = linear.
- Lat  in  4  read latency.
- Pre  in  8  post-precharge wait period.
- Wait  in  8  post-transaction precharge wait period.
- Cas  in  8  CAS period.
- CS  out  1  chip select, active-low.
- RAS  out  1  row strobe, active-low.
- CAS  out  1  column strobe, active-low.
- WeOut  out  1  write enable, active-low.
- AddrOut  out  32  packed mode word.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse on an invalid BurstLen.
- TimingLocked  out  1  set once the first MRS has been issued since reset.

Behaviour:
- All outputs are registered.
- NOP means CS=RAS=CAS=WeOut=1 and AddrOut=0.
- Reset (async, Rst=0):
  - Bus is NOP; Busy=1; Done=Err=TimingLocked=0.
  - Counter is cleared; FSM enters PWRUP.
- FSM states: PWRUP, IDLE, MRS, WAIT.
- PWRUP:
  - Bus is NOP; counter counts up to PWRUP_CYCLES, then the FSM moves to IDLE.
  - Req is ignored.
- IDLE:
  - Busy=0 and bus is NOP.
  - On an edge where Req=1, all field inputs are captured on that edge.
  - If BurstLen is valid: next cycle is MRS.
  - If BurstLen is invalid: Err=1 for exactly one cycle in the next cycle, bus stays NOP, FSM remains in IDLE, TimingLocked is unchanged.
- Burst encoding to AddrOut[2:0]: 1→0, 2→1, 4→2, 8→3, 16→4, 32→5, 64→6, 255→7. Any other value is invalid.
- AddrOut packing: [2:0] burst config, [3] AddrMode, [7:4] Lat, [15:8] Pre, [23:16] Wait, [31:24] Cas.
- MRS:
  - Exactly one cycle with CS=RAS=CAS=WeOut=0 and AddrOut = packed word.
  - TimingLocked is set at the end of this cycle and stays set until reset.
  - Timing fields are still driven after lock; the device ignores them.
- WAIT:
  - TMRD NOP cycles.
  - In the following cycle Done=1, Busy=0 and the FSM is in IDLE. A Req in that cycle is accepted.
- Latency: request edge k → MRS on the bus during cycle k+1 → Done during cycle k+2+TMRD.
- Req while Busy=1 is ignored; the request is not queued.
- Field inputs are don't-care outside the accepting edge.
- Done and Err are never asserted together.
- Reset mid-operation:
  - Bus returns to NOP immediately, including mid-MRS.
  - Any pending Done is cancelled; TimingLocked is cleared.
  - Power-up restarts.

Optional Feature:
- Macro: SDRAM_MRS_AUTOINIT_EN.
- Defined: PWRUP exits directly to MRS with AddrOut=DEF_MODE, followed by WAIT and Done as normal, with no Req needed. Busy stays 1 throughout. Host requests are accepted afterwards.
- Undefined: PWRUP exits to IDLE and waits for Req; DEF_MODE is unused.

Test Plan:
1. Release Rst, PWRUP_CYCLES=16 → Busy=1 and bus NOP for 16 cycles, then Busy=0; Req pulsed at cycle 5 produces no command.
2. In IDLE, Req with BurstLen=8, AddrMode=1, Lat=3, Pre=0x12, Wait=0x34, Cas=0x56 → next cycle CS=RAS=CAS=WeOut=0 with AddrOut=0x5634123B, then 2 NOP cycles, then Done=1 for one cycle; TimingLocked=1 thereafter.
3. Req with BurstLen=255, then BurstLen=1 → AddrOut[2:0]=7, then 0. Req with BurstLen=3 → Err pulse one cycle later, bus stays NOP, no Done.
4. Second Req held during WAIT → ignored, only one MRS cycle seen. The same Req still high in the Done cycle is accepted, giving a second MRS on the next cycle.
5. Assert Rst during WAIT (and separately during the MRS cycle) → bus NOP immediately, TimingLocked=0, no Done, full 16-cycle PWRUP repeats.
6. With SDRAM_MRS_AUTOINIT_EN defined → MRS with AddrOut=0x04020130 on the cycle after PWRUP without Req, Done 3 cycles later; undefined → no command until Req.

Source files
------------

// File: rtl/sdram_mrs_issuer.sv
// SDRAM mode-register-set initiator: power-up NOP hold, request capture, MRS issue, tMRD wait, Done.
// Optional SDRAM_MRS_AUTOINIT_EN: issue DEF_MODE automatically when power-up completes.
module sdram_mrs_issuer #(
  parameter int          PWRUP_CYCLES = 16,
  parameter int          TMRD         = 2,
  parameter int          CNT_W        = 8,
  parameter logic [31:0] DEF_MODE     = 32'h0402_0130
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [7:0]  BurstLen,
  input  logic        AddrMode,
  input  logic [3:0]  Lat,
  input  logic [7:0]  Pre,
  input  logic [7:0]  Wait,
  input  logic [7:0]  Cas,
  output logic        CS,
  output logic        RAS,
  output logic        CAS,
  output logic        WeOut,
  output logic [31:0] AddrOut,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        TimingLocked
);

  typedef enum logic [1:0] {ST_PWRUP, ST_IDLE, ST_MRS, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMRD_LAST  = CNT_W'(TMRD - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              cmd_n_reg;
  logic [31:0]       addr_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              locked_reg;

  logic [7:0]        burst_match;
  logic [2:0]        burst_code;
  logic              burst_valid;
  logic [31:0]       mode_word;

  // One-hot match of the legal burst lengths; bit position is the encoded value.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_burst
      assign burst_match[gi] = (BurstLen == 8'(1 << gi));
    end
  endgenerate
  assign burst_match[7] = (BurstLen == 8'd255);

  always_comb begin
    burst_code = '0;
    for (int i = 0; i < 8; i++) begin
      if (burst_match[i]) burst_code = 3'(i);
    end
  end

  assign burst_valid = |burst_match;
  assign mode_word   = {Cas, Wait, Pre, Lat, AddrMode, burst_code};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg  <= ST_PWRUP;
      cnt_reg    <= '0;
      cmd_n_reg  <= 1'b1;
      addr_reg   <= '0;
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      // Bus defaults to NOP and pulses default low; states override below.
      cmd_n_reg <= 1'b1;
      addr_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        ST_PWRUP: begin
          if (cnt_reg == PWRUP_LAST) begin
            cnt_reg   <= '0;
`ifdef SDRAM_MRS_AUTOINIT_EN
            state_reg <= ST_MRS;
            cmd_n_reg <= 1'b0;
            addr_reg  <= DEF_MODE;
`else
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (Req) begin
            if (burst_valid) begin
              state_reg <= ST_MRS;
              cmd_n_reg <= 1'b0;
              addr_reg  <= mode_word;
              busy_reg  <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_MRS: begin
          state_reg  <= ST_WAIT;
          cnt_reg    <= '0;
          locked_reg <= 1'b1;
        end
        ST_WAIT: begin
          if (cnt_reg == TMRD_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_PWRUP;
          cnt_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  // The four command strobes are identical for both NOP and MRS.
  assign CS           = cmd_n_reg;
  assign RAS          = cmd_n_reg;
  assign CAS          = cmd_n_reg;
  assign WeOut        = cmd_n_reg;
  assign AddrOut      = addr_reg;
  assign Busy         = busy_reg;
  assign Done         = done_reg;
  assign Err          = err_reg;
  assign TimingLocked = locked_reg;

endmodule
